// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs (a = bit 0)
// and the scan FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_e;

endpackage

// File: rtl/seg_glyph.sv
// Combinational nibble-to-glyph decoder (active-low segments g..a).
// Values 10..15 decode to hex letters only when hex_en_i is set, otherwise blank.
module seg_glyph
  import seg_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       hex_en_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = SEG_BLANK;
    case (value_i)
      4'h0: glyph_o = SEG_0;
      4'h1: glyph_o = SEG_1;
      4'h2: glyph_o = SEG_2;
      4'h3: glyph_o = SEG_3;
      4'h4: glyph_o = SEG_4;
      4'h5: glyph_o = SEG_5;
      4'h6: glyph_o = SEG_6;
      4'h7: glyph_o = SEG_7;
      4'h8: glyph_o = SEG_8;
      4'h9: glyph_o = SEG_9;
      4'hA: glyph_o = SEG_A;
      4'hB: glyph_o = SEG_B;
      4'hC: glyph_o = SEG_C;
      4'hD: glyph_o = SEG_D;
      4'hE: glyph_o = SEG_E;
      4'hF: glyph_o = SEG_F;
      default: glyph_o = SEG_BLANK;
    endcase
    if (!hex_en_i && (value_i > 4'd9)) glyph_o = SEG_BLANK;
  end

endmodule

// File: rtl/seg_scan_drv.sv
// Time-multiplexed common-anode seven-segment driver with per-slot dead-time.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   num_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  hex_en,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     sel_out,
  output logic                  frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CntBlankLast = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] CntSlotLast  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IdxLast      = IW'(DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frame_q, frame_d;
  logic          wrap;

  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              tick_q, tick_d;

  logic [3:0]        cur_nib;
  logic [6:0]        cur_glyph;
  logic [DIGITS-1:0] lzb;

  // Slot counter runs 0..SCAN_DIV-1 across the whole slot; BLANK covers the first BLANK_CYC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntBlankLast) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == CntSlotLast) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (idx_q == IdxLast) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
    frame_d = wrap;
  end

  // A load coinciding with a frame start bypasses pend so it shows in that very frame.
  always_comb begin
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_vld_d  = pend_vld_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (load) begin
      pend_d     = num_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
    if ((state_q == IDLE) || wrap) begin
      pend_vld_d = 1'b0;
      if (load) begin
        shadow_d    = num_in;
        shadow_dp_d = dp_in;
      end else if (pend_vld_q || (state_q == IDLE)) begin
        shadow_d    = pend_q;
        shadow_dp_d = pend_dp_q;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic lzb_lead;

  always_comb begin
    lzb      = '0;
    lzb_lead = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      if (lzb_lead && (shadow_q[4*k +: 4] == 4'h0)) begin
        lzb[k] = 1'b1;
      end else begin
        lzb_lead = 1'b0;
      end
    end
  end
`else
  always_comb begin
    lzb = '0;
  end
`endif

  assign cur_nib = shadow_q[{idx_q, 2'b00} +: 4];

  seg_glyph u_glyph (
    .value_i  (cur_nib),
    .hex_en_i (hex_en),
    .glyph_o  (cur_glyph)
  );

  always_comb begin
    sel_d  = '1;
    seg_d  = 8'hFF;
    tick_d = frame_q;
    if (state_q == SHOW) begin
      sel_d[idx_q] = 1'b0;
      seg_d        = {~shadow_dp_q[idx_q], (lzb[idx_q] ? SEG_BLANK : cur_glyph)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_q     <= 1'b0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_vld_q  <= 1'b0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      seg_q       <= 8'hFF;
      sel_q       <= '1;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_vld_q  <= pend_vld_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      tick_q      <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign sel_out    = sel_q;
  assign frame_tick = tick_q;

endmodule
